// File: rtl/clk_gen_multiphase_pkg.sv
// rtl/clk_gen_multiphase_pkg.sv - shared defaults, channel state encoding and phase-default helper
package clk_gen_multiphase_pkg;

   localparam int CLK_DEF_CNT_W = 11;
   localparam int CLK_DEF_HALF  = 125;
   localparam int CLK_DEF_PHASE = 62;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } chan_state_t;

   // Channel 0 is the phase reference; every other channel starts at the shared default offset.
   function automatic int chan_def_phase(input int ch, input int def_phase);
      return (ch == 0) ? 0 : def_phase;
   endfunction

endpackage

// File: rtl/clk_gen_multiphase_chan.sv
// rtl/clk_gen_multiphase_chan.sv - one divided-clock channel: counter, run/idle FSM, shadow/active config, strobes
module clk_gen_multiphase_chan
   import clk_gen_multiphase_pkg::*;
#(
   parameter int CNT_W     = CLK_DEF_CNT_W,
   parameter int DEF_HALF  = CLK_DEF_HALF,
   parameter int DEF_PHASE = CLK_DEF_PHASE
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_half,
   input  logic [CNT_W-1:0] i_phase,
   output logic             o_clk,
   output logic             o_rise,
   output logic             o_fall,
   output logic             o_pend
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

   chan_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_half;
   logic [CNT_W-1:0] r_phase;
   logic [CNT_W-1:0] r_sh_half;
   logic [CNT_W-1:0] r_sh_phase;
   logic             r_clk;
   logic             r_rise;
   logic             r_fall;
   logic             r_pend;

   logic [CNT_W-1:0] w_half_c;
   logic [CNT_W-1:0] w_phase_c;
   logic             w_tc;

   // Clamp once at write time so the active pair is always consistent (phase < half, half >= 2).
   assign w_half_c  = (i_half < TWO) ? TWO : i_half;
   assign w_phase_c = (i_phase >= w_half_c) ? (w_half_c - ONE) : i_phase;
   assign w_tc      = (r_cnt == (r_half - ONE));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_half     <= CNT_W'(DEF_HALF);
         r_phase    <= CNT_W'(DEF_PHASE);
         r_sh_half  <= CNT_W'(DEF_HALF);
         r_sh_phase <= CNT_W'(DEF_PHASE);
         r_clk      <= 1'b0;
         r_rise     <= 1'b0;
         r_fall     <= 1'b0;
         r_pend     <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_clk <= 1'b0;
            r_cnt <= '0;
            if (i_en) begin
               r_state <= ST_RUN;
               if (r_pend) begin
                  r_half  <= r_sh_half;
                  r_phase <= r_sh_phase;
                  r_cnt   <= r_sh_phase;
                  r_pend  <= 1'b0;
               end else begin
                  r_cnt <= r_phase;
               end
            end
         end else if (!i_en) begin
            r_state <= ST_IDLE;
            r_clk   <= 1'b0;
            r_cnt   <= '0;
            r_fall  <= r_clk;
         end else if (w_tc) begin
            r_cnt  <= '0;
            r_clk  <= ~r_clk;
            r_rise <= ~r_clk;
            r_fall <= r_clk;
            // Live config swaps only at the end of a high half so no runt pulse escapes.
            if (r_clk && r_pend) begin
               r_half  <= r_sh_half;
               r_phase <= r_sh_phase;
               r_pend  <= 1'b0;
            end
         end else begin
            r_cnt <= r_cnt + ONE;
         end
         // A write in the same cycle as an apply re-arms pend with the newer values.
         if (i_wr) begin
            r_sh_half  <= w_half_c;
            r_sh_phase <= w_phase_c;
            r_pend     <= 1'b1;
         end
      end
   end

   assign o_clk  = r_clk;
   assign o_rise = r_rise;
   assign o_fall = r_fall;
   assign o_pend = r_pend;

endmodule

// File: rtl/clk_gen_multiphase.sv
// rtl/clk_gen_multiphase.sv - N-channel phase-aligned divided-clock / strobe generator
module clk_gen_multiphase
   import clk_gen_multiphase_pkg::*;
#(
   parameter  int N_CH      = 2,
   parameter  int CNT_W     = CLK_DEF_CNT_W,
   parameter  int DEF_HALF  = CLK_DEF_HALF,
   parameter  int DEF_PHASE = CLK_DEF_PHASE,
   // One spare bit so out-of-range channel numbers can be presented and rejected.
   localparam int CH_W      = $clog2(N_CH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,
   input  logic              i_cfg_wr,
   input  logic [CH_W-1:0]   i_cfg_ch,
   input  logic [CNT_W-1:0]  i_cfg_half,
   input  logic [CNT_W-1:0]  i_cfg_phase,
   output logic [N_CH-1:0]   o_clk_out,
   output logic [N_CH-1:0]   o_rise_stb,
   output logic [N_CH-1:0]   o_fall_stb,
   output logic [N_CH-1:0]   o_cfg_pend
);

   logic [N_CH-1:0] w_wr;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_wr[g] = i_cfg_wr && (i_cfg_ch == CH_W'(g));

      clk_gen_multiphase_chan #(
         .CNT_W     (CNT_W),
         .DEF_HALF  (DEF_HALF),
         .DEF_PHASE (chan_def_phase(g, DEF_PHASE))
      ) u_chan (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_en    (i_en),
         .i_wr    (w_wr[g]),
         .i_half  (i_cfg_half),
         .i_phase (i_cfg_phase),
         .o_clk   (o_clk_out[g]),
         .o_rise  (o_rise_stb[g]),
         .o_fall  (o_fall_stb[g]),
         .o_pend  (o_cfg_pend[g])
      );
   end

endmodule

// File: tb/tb_clk_gen_multiphase.sv
// tb/tb_clk_gen_multiphase.sv - directed scenarios plus random traffic against an edge-countdown reference model
module tb_clk_gen_multiphase;

   localparam int N_CH  = 2;
   localparam int CNT_W = 11;
   localparam int CH_W  = $clog2(N_CH) + 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              cfg_wr = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [CNT_W-1:0]  cfg_half = '0;
   logic [CNT_W-1:0]  cfg_phase = '0;
   logic [N_CH-1:0]   clk_out, rise_stb, fall_stb, cfg_pend;

   int n_checks = 0;
   int n_errors = 0;

   // Reference: each running channel holds the number of cycles left until its next edge.
   int m_run[N_CH], m_lvl[N_CH], m_left[N_CH], m_half[N_CH], m_phase[N_CH];
   int m_sh_half[N_CH], m_sh_phase[N_CH], m_pend[N_CH], m_rise[N_CH], m_fall[N_CH];

   always #10 clk = ~clk;

   clk_gen_multiphase #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_cfg_wr    (cfg_wr),
      .i_cfg_ch    (cfg_ch),
      .i_cfg_half  (cfg_half),
      .i_cfg_phase (cfg_phase),
      .o_clk_out   (clk_out),
      .o_rise_stb  (rise_stb),
      .o_fall_stb  (fall_stb),
      .o_cfg_pend  (cfg_pend)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < N_CH; c++) begin
         m_run[c] = 0; m_lvl[c] = 0; m_left[c] = 0; m_pend[c] = 0;
         m_rise[c] = 0; m_fall[c] = 0;
         m_half[c] = 125; m_phase[c] = (c == 0) ? 0 : 62;
         m_sh_half[c] = m_half[c]; m_sh_phase[c] = m_phase[c];
      end
   endtask

   task automatic model_step();
      int h;
      for (int c = 0; c < N_CH; c++) begin
         m_rise[c] = 0;
         m_fall[c] = 0;
         if (m_run[c] == 0) begin
            if (en) begin
               if (m_pend[c] != 0) begin
                  m_half[c] = m_sh_half[c]; m_phase[c] = m_sh_phase[c]; m_pend[c] = 0;
               end
               m_run[c] = 1; m_lvl[c] = 0;
               m_left[c] = m_half[c] - m_phase[c];
            end
         end else if (!en) begin
            m_run[c] = 0; m_fall[c] = m_lvl[c]; m_lvl[c] = 0;
         end else begin
            m_left[c]--;
            if (m_left[c] == 0) begin
               m_lvl[c] = 1 - m_lvl[c];
               m_rise[c] = m_lvl[c];
               m_fall[c] = 1 - m_lvl[c];
               m_left[c] = m_half[c];
               if (m_lvl[c] == 0 && m_pend[c] != 0) begin
                  m_half[c] = m_sh_half[c]; m_phase[c] = m_sh_phase[c]; m_pend[c] = 0;
                  m_left[c] = m_half[c];
               end
            end
         end
         if (cfg_wr && int'(cfg_ch) == c) begin
            h = (int'(cfg_half) < 2) ? 2 : int'(cfg_half);
            m_sh_half[c] = h;
            m_sh_phase[c] = (int'(cfg_phase) >= h) ? h - 1 : int'(cfg_phase);
            m_pend[c] = 1;
         end
      end
   endtask

   task automatic compare_all();
      for (int c = 0; c < N_CH; c++) begin
         check_eq($sformatf("clk_out%0d", c), int'(clk_out[c]), m_lvl[c]);
         check_eq($sformatf("rise_stb%0d", c), int'(rise_stb[c]), m_rise[c]);
         check_eq($sformatf("fall_stb%0d", c), int'(fall_stb[c]), m_fall[c]);
         check_eq($sformatf("cfg_pend%0d", c), int'(cfg_pend[c]), m_pend[c]);
      end
      check_eq("stb_exclusive", int'(rise_stb & fall_stb), 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic write_cfg(input int ch, input int h, input int p);
      cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(h); cfg_phase = CNT_W'(p);
      tick();
      cfg_wr = 1'b0;
   endtask

   task automatic wait_rise(input int c, output int n);
      n = -1;
      for (int i = 1; i <= 2000; i++) begin
         tick();
         if (rise_stb[c]) begin n = i; break; end
      end
      if (n < 0) check_eq("rise_timeout", int'(rise_stb[c]), 1);
   endtask

   task automatic wait_fall(input int c, output int n);
      n = -1;
      for (int i = 1; i <= 2000; i++) begin
         tick();
         if (fall_stb[c]) begin n = i; break; end
      end
      if (n < 0) check_eq("fall_timeout", int'(fall_stb[c]), 1);
   endtask

   task automatic pulse_reset();
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_eq("arst_clk_out", int'(clk_out), 0);
      check_eq("arst_rise", int'(rise_stb), 0);
      check_eq("arst_fall", int'(fall_stb), 0);
      check_eq("arst_pend", int'(cfg_pend), 0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic measure_start(input string tag);
      int f0, f1, s0;
      f0 = -1; f1 = -1; s0 = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (rise_stb[0]) begin
            if (f0 < 0) f0 = i;
            else if (s0 < 0) s0 = i;
         end
         if (rise_stb[1] && f1 < 0) f1 = i;
      end
      check_eq({tag, "_ch0_first_rise"}, f0, 125);
      check_eq({tag, "_ch1_first_rise"}, f1, 63);
      check_eq({tag, "_ch0_second_rise"}, s0, 375);
   endtask

   initial begin
      int a, b;
      model_reset();
      #25;
      check_eq("rst_clk_out", int'(clk_out), 0);
      check_eq("rst_rise", int'(rise_stb), 0);
      check_eq("rst_fall", int'(fall_stb), 0);
      check_eq("rst_pend", int'(cfg_pend), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Defaults: 200 kHz, ch1 62 cycles ahead.
      en = 1'b1;
      measure_start("s1");

      // Live retune of ch0.
      write_cfg(0, 10, 0);
      check_eq("s2_pend_set", int'(cfg_pend[0]), 1);
      wait_fall(0, a);
      check_eq("s2_pend_clr", int'(cfg_pend[0]), 0);
      wait_rise(0, a);
      wait_rise(0, b);
      check_eq("s2_period", b, 20);

      // Clamped write to ch1.
      write_cfg(1, 1, 9);
      repeat (300) tick();
      wait_rise(1, a);
      wait_rise(1, b);
      check_eq("s3_period", b, 4);

      // Stop mid-high.
      for (int i = 0; i < 100 && !clk_out[0]; i++) tick();
      en = 1'b0;
      tick();
      check_eq("s4_clk0_low", int'(clk_out[0]), 0);
      check_eq("s4_fall0", int'(fall_stb[0]), 1);
      repeat (5) tick();
      en = 1'b1;
      repeat (300) tick();

      // Write landing exactly on the apply edge.
      for (int i = 0; i < 100 && m_lvl[0] != 0; i++) tick();
      write_cfg(0, 8, 0);
      for (int i = 0; i < 100 && !(m_lvl[0] == 1 && m_left[0] == 1); i++) tick();
      write_cfg(0, 6, 2);
      check_eq("s5_pend_held", int'(cfg_pend[0]), 1);
      wait_fall(0, a);
      check_eq("s5_pend_clr", int'(cfg_pend[0]), 0);
      wait_rise(0, a);
      wait_rise(0, b);
      check_eq("s5_period", b, 12);
      write_cfg(3, 5, 1);
      check_eq("s5_bad_ch_ignored", int'(cfg_pend), 0);

      // Asynchronous reset mid-count, then default timing again.
      repeat (37) tick();
      pulse_reset();
      measure_start("s6");

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         if ($urandom_range(0, 39) == 0) begin
            cfg_wr = 1'b1;
            cfg_ch = CH_W'($urandom_range(0, 3));
            cfg_half = CNT_W'($urandom_range(0, 40));
            cfg_phase = CNT_W'($urandom_range(0, 45));
         end
         tick();
         cfg_wr = 1'b0;
         if ($urandom_range(0, 999) == 0) pulse_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
